// File: rtl/apuracao_votos_pkg.sv
// rtl/apuracao_votos_pkg.sv - shared state encoding and candidate/winner codes
package apuracao_votos_pkg;

  typedef enum logic [1:0] {
    CONTANDO  = 2'd0,
    APURANDO  = 2'd1,
    ENCERRADO = 2'd2
  } estado_t;

  // Candidate indices are also the winner codes; the ballot box uses the same numbering.
  localparam logic [2:0] ARTHUR  = 3'd0;
  localparam logic [2:0] LEANDRO = 3'd1;
  localparam logic [2:0] MATEUS  = 3'd2;
  localparam logic [2:0] PABLO   = 3'd3;
  localparam logic [2:0] NENHUM  = 3'd7;

  localparam int N_CAND  = 4;
  localparam int N_FLAGS = 5;

endpackage

// File: rtl/apuracao_votos_contador_saturado.sv
// rtl/apuracao_votos_contador_saturado.sv - rising-edge vote counter that saturates at all-ones
module contador_saturado #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             flag,
  output logic [CNT_W-1:0] count,
  output logic             inc,
  output logic             overflow
);

  logic prev;
  logic rise;

  // History tracks the flag in every state so a held flag never recounts after a state change.
  assign rise     = flag & ~prev;
  assign inc      = enable & rise & (count != '1);
  assign overflow = enable & rise & (count == '1);

  always_ff @(posedge clock) begin
    if (reset) begin
      prev  <= 1'b0;
      count <= '0;
    end else begin
      prev <= flag;
      if (inc) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/apuracao_votos.sv
// rtl/apuracao_votos.sv - vote tally with winner/tie scan after end of election
module apuracao_votos
  import apuracao_votos_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             candidatoArthur,
  input  logic             candidatoLeandro,
  input  logic             candidatoMateus,
  input  logic             candidatoPablo,
  input  logic             candidatoNulo,
  input  logic             finish,
  output logic [CNT_W-1:0] votos_arthur,
  output logic [CNT_W-1:0] votos_leandro,
  output logic [CNT_W-1:0] votos_mateus,
  output logic [CNT_W-1:0] votos_pablo,
  output logic [CNT_W-1:0] votos_nulo,
  output logic [CNT_W+2:0] total_votos,
  output logic [2:0]       vencedor,
  output logic             empate,
  output logic             resultado_pronto,
  output logic             saturado
);

  estado_t state, state_next;

  logic [N_FLAGS-1:0] flags;
  logic [CNT_W-1:0]   cnt [N_FLAGS];
  logic [N_FLAGS-1:0] inc;
  logic [N_FLAGS-1:0] ovf;
  logic               contando;
  logic [2:0]         inc_sum;

  logic [1:0]         idx;
  logic [CNT_W-1:0]   best_cnt;
  logic [2:0]         best_idx;
  logic               empate_r;
  logic [CNT_W-1:0]   cur;

  assign flags    = {candidatoNulo, candidatoPablo, candidatoMateus, candidatoLeandro, candidatoArthur};
  assign contando = (state == CONTANDO);

  for (genvar i = 0; i < N_FLAGS; i++) begin : g_cnt
    contador_saturado #(.CNT_W(CNT_W)) u_cnt (
      .clock    (clock),
      .reset    (reset),
      .enable   (contando),
      .flag     (flags[i]),
      .count    (cnt[i]),
      .inc      (inc[i]),
      .overflow (ovf[i])
    );
  end

  assign votos_arthur  = cnt[0];
  assign votos_leandro = cnt[1];
  assign votos_mateus  = cnt[2];
  assign votos_pablo   = cnt[3];
  assign votos_nulo    = cnt[4];

  always_comb begin
    inc_sum = '0;
    for (int i = 0; i < N_FLAGS; i++) begin
      inc_sum = inc_sum + {2'b00, inc[i]};
    end
  end

  // Accumulating accepted increments keeps the total in step with the counters it sums.
  always_ff @(posedge clock) begin
    if (reset) begin
      total_votos <= '0;
      saturado    <= 1'b0;
    end else begin
      total_votos <= total_votos + {{CNT_W{1'b0}}, inc_sum};
      if (|ovf) begin
        saturado <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= CONTANDO;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      CONTANDO:  if (finish) state_next = APURANDO;
      APURANDO:  if (idx == 2'd3) state_next = ENCERRADO;
      ENCERRADO: state_next = ENCERRADO;
      default:   state_next = CONTANDO;
    endcase
  end

  assign cur = cnt[{1'b0, idx}];

  // Strict greater-than keeps the lowest index on ties; a new leader clears an earlier tie.
  always_ff @(posedge clock) begin
    if (reset || state == CONTANDO) begin
      idx      <= 2'd0;
      best_cnt <= '0;
      best_idx <= NENHUM;
      empate_r <= 1'b0;
    end else if (state == APURANDO) begin
      idx <= idx + 2'd1;
      if (cur > best_cnt) begin
        best_cnt <= cur;
        best_idx <= {1'b0, idx};
        empate_r <= 1'b0;
      end else if (cur == best_cnt && best_cnt != '0) begin
        empate_r <= 1'b1;
      end
    end
  end

  always_comb begin
    resultado_pronto = (state == ENCERRADO);
    vencedor         = resultado_pronto ? best_idx : NENHUM;
    empate           = resultado_pronto & empate_r;
  end

endmodule

// File: tb/tb_apuracao_votos.sv
// tb/tb_apuracao_votos.sv - scoreboard bench for apuracao_votos at CNT_W=8 and CNT_W=2
module tb_apuracao_votos;

  typedef struct packed {
    logic [4:0][7:0] cnt;
    logic [10:0]     total;
    logic [2:0]      venc;
    logic            emp;
    logic            sat;
    logic [31:0]     fcyc;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] fl = 5'd0;
  logic       finish = 1'b0;

  logic [7:0]  c1 [5];
  logic [10:0] t1;
  logic [2:0]  w1;
  logic        e1, r1, s1;
  logic [1:0]  c2 [5];
  logic [4:0]  t2;
  logic [2:0]  w2;
  logic        e2, r2, s2;

  int total_n = 0;
  int bad_n = 0;
  int cyc = 0;
  int mod1 [5];
  int mod2 [5];
  int sat1, sat2;
  exp_t q1 [$];
  exp_t q2 [$];
  exp_t ex1, ex2;
  logic rp1 = 1'b0;
  logic rp2 = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  apuracao_votos #(.CNT_W(8)) dut1 (
    .clock(clock), .reset(reset),
    .candidatoArthur(fl[0]), .candidatoLeandro(fl[1]), .candidatoMateus(fl[2]),
    .candidatoPablo(fl[3]), .candidatoNulo(fl[4]), .finish(finish),
    .votos_arthur(c1[0]), .votos_leandro(c1[1]), .votos_mateus(c1[2]),
    .votos_pablo(c1[3]), .votos_nulo(c1[4]), .total_votos(t1),
    .vencedor(w1), .empate(e1), .resultado_pronto(r1), .saturado(s1)
  );

  apuracao_votos #(.CNT_W(2)) dut2 (
    .clock(clock), .reset(reset),
    .candidatoArthur(fl[0]), .candidatoLeandro(fl[1]), .candidatoMateus(fl[2]),
    .candidatoPablo(fl[3]), .candidatoNulo(fl[4]), .finish(finish),
    .votos_arthur(c2[0]), .votos_leandro(c2[1]), .votos_mateus(c2[2]),
    .votos_pablo(c2[3]), .votos_nulo(c2[4]), .total_votos(t2),
    .vencedor(w2), .empate(e2), .resultado_pronto(r2), .saturado(s2)
  );

  task automatic chk(string nm, int act, int exp);
    total_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 5; i++) begin
      mod1[i] = 0;
      mod2[i] = 0;
    end
    sat1 = 0;
    sat2 = 0;
  endtask

  task automatic model_vote(logic [4:0] mask);
    for (int i = 0; i < 5; i++) begin
      if (mask[i]) begin
        if (mod1[i] < 255) mod1[i]++; else sat1 = 1;
        if (mod2[i] < 3) mod2[i]++; else sat2 = 1;
      end
    end
  endtask

  // Winner = first candidate holding the maximum; tie when more than one holds a nonzero maximum.
  function automatic exp_t mk(bit two, int fc);
    exp_t e;
    int c [5];
    int best, nmax, sum;
    best = 0; nmax = 0; sum = 0;
    for (int i = 0; i < 5; i++) begin
      c[i] = two ? mod2[i] : mod1[i];
      sum += c[i];
      e.cnt[i] = 8'(c[i]);
    end
    for (int i = 0; i < 4; i++) if (c[i] > best) best = c[i];
    e.venc = 3'd7;
    for (int i = 3; i >= 0; i--) begin
      if (best != 0 && c[i] == best) begin
        e.venc = 3'(i);
        nmax++;
      end
    end
    e.emp   = (nmax > 1);
    e.total = 11'(sum);
    e.sat   = two ? sat2[0] : sat1[0];
    e.fcyc  = 32'(fc);
    return e;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    fl = 5'd0;
    finish = 1'b0;
    tick(2);
    reset = 1'b0;
    clear_model();
  endtask

  task automatic vote(logic [4:0] mask, int hold);
    fl = mask;
    model_vote(mask);
    tick(hold);
    fl = 5'd0;
    tick(1);
  endtask

  task automatic do_finish(logic [4:0] mask, int flen);
    fl = mask;
    finish = 1'b1;
    model_vote(mask);
    q1.push_back(mk(1'b0, cyc));
    q2.push_back(mk(1'b1, cyc));
    tick(1);
    fl = 5'd0;
    if (flen > 1) tick(flen - 1);
    finish = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!r1 && k < 20) begin
      tick(1);
      k++;
    end
    chk("done_timeout", int'(r1), 1);
    tick(1);
  endtask

  always @(negedge clock) begin
    if (r1 && !rp1) begin
      if (q1.size() == 0) begin
        total_n++;
        bad_n++;
        $display("FAIL sb1_unexpected: got result expected none");
      end else begin
        ex1 = q1.pop_front();
        for (int i = 0; i < 5; i++) chk($sformatf("sb1_cnt%0d", i), int'(c1[i]), int'(ex1.cnt[i]));
        chk("sb1_total", int'(t1), int'(ex1.total));
        chk("sb1_vencedor", int'(w1), int'(ex1.venc));
        chk("sb1_empate", int'(e1), int'(ex1.emp));
        chk("sb1_saturado", int'(s1), int'(ex1.sat));
        chk("sb1_latency", cyc - int'(ex1.fcyc), 5);
      end
    end
    rp1 = r1;
  end

  always @(negedge clock) begin
    if (r2 && !rp2) begin
      if (q2.size() == 0) begin
        total_n++;
        bad_n++;
        $display("FAIL sb2_unexpected: got result expected none");
      end else begin
        ex2 = q2.pop_front();
        for (int i = 0; i < 5; i++) chk($sformatf("sb2_cnt%0d", i), int'(c2[i]), int'(ex2.cnt[i]));
        chk("sb2_total", int'(t2), int'(ex2.total));
        chk("sb2_vencedor", int'(w2), int'(ex2.venc));
        chk("sb2_empate", int'(e2), int'(ex2.emp));
        chk("sb2_saturado", int'(s2), int'(ex2.sat));
        chk("sb2_latency", cyc - int'(ex2.fcyc), 5);
      end
    end
    rp2 = r2;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    tick(2);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) chk($sformatf("rst_cnt%0d", i), int'(c1[i]), 0);
    chk("rst_total", int'(t1), 0);
    chk("rst_vencedor", int'(w1), 7);
    chk("rst_empate", int'(e1), 0);
    chk("rst_pronto", int'(r1), 0);
    chk("rst_saturado", int'(s1), 0);

    // long-held flag counts once per rise
    repeat (3) vote(5'b00001, 10);
    chk("held_arthur", int'(c1[0]), 3);
    chk("held_total", int'(t1), 3);
    chk("held_leandro", int'(c1[1]), 0);
    chk("held_nulo", int'(c1[4]), 0);
    do_finish(5'd0, 1);
    wait_done();

    do_reset();
    repeat (2) vote(5'b00010, 1);
    repeat (5) vote(5'b00100, 2);
    vote(5'b01000, 1);
    repeat (4) vote(5'b10000, 1);
    do_finish(5'd0, 1);
    wait_done();
    chk("mix_vencedor", int'(w1), 2);
    chk("mix_empate", int'(e1), 0);
    chk("mix_total", int'(t1), 12);

    do_reset();
    repeat (3) vote(5'b01001, 1);
    do_finish(5'd0, 2);
    wait_done();
    chk("tie_vencedor", int'(w1), 0);
    chk("tie_empate", int'(e1), 1);

    do_reset();
    do_finish(5'd0, 1);
    wait_done();
    chk("none_vencedor", int'(w1), 7);
    chk("none_total", int'(t1), 0);

    do_reset();
    repeat (6) vote(5'b10000, 1);
    do_finish(5'd0, 1);
    wait_done();
    chk("nulo_vencedor", int'(w1), 7);
    chk("nulo_count", int'(c1[4]), 6);

    do_reset();
    repeat (4) vote(5'b00001, 1);
    chk("sat_w2_count", int'(c2[0]), 3);
    chk("sat_w2_flag", int'(s2), 1);
    chk("sat_w8_flag", int'(s1), 0);
    do_finish(5'b00100, 1);
    wait_done();

    // reset lands on the second scan cycle
    do_reset();
    vote(5'b00101, 1);
    finish = 1'b1;
    tick(1);
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    finish = 1'b0;
    clear_model();
    chk("abort_arthur", int'(c1[0]), 0);
    chk("abort_mateus", int'(c1[2]), 0);
    chk("abort_pronto", int'(r1), 0);
    chk("abort_vencedor", int'(w1), 7);
    vote(5'b00001, 1);
    chk("abort_counting", int'(c1[0]), 1);
    do_finish(5'b01000, 1);
    wait_done();

    // activity in ENCERRADO must not disturb frozen results
    fl = 5'b11111;
    finish = 1'b1;
    tick(2);
    fl = 5'd0;
    finish = 1'b0;
    tick(1);
    vote_frozen_check: for (int i = 0; i < 5; i++) chk($sformatf("frozen_cnt%0d", i), int'(c1[i]), mod1[i]);
    chk("frozen_pronto", int'(r1), 1);
    chk("frozen_total", int'(t1), 2);

    for (int n = 0; n < 25; n++) begin
      int np;
      do_reset();
      np = int'($urandom_range(0, 10));
      for (int k = 0; k < np; k++) vote(5'($urandom_range(0, 31)), int'($urandom_range(1, 3)));
      do_finish(($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 31)) : 5'd0, int'($urandom_range(1, 3)));
      wait_done();
    end

    chk("queues_drained", q1.size() + q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
